// File: rtl/calc_pkg.sv
// Shared opcode encodings, sequencer states and the default error pattern for the calculator block.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        CONV = 3'd2,
        DONE = 3'd3,
        SHOW = 3'd4
    } state_t;

    localparam logic [31:0] ERR_PATTERN_DEFAULT = 32'hEEEE_EEEE;

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble converter: start loads bin, done pulses once bcd holds the result.
// Used by calc_ctrl only when CALC_BCD_EN is defined.
module calc_bin2bcd #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] bcd,
    output logic             done
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] sh;
    logic [2*WIDTH-1:0] adj;
    logic [CW-1:0]      cnt;
    logic               running;

    always_comb begin
        adj = sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = sh[WIDTH+4*i +: 4] + 4'd3;
            end
        end
    end

    // The load performs the first shift itself: with all digits zero no adjust is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                running <= 1'b0;
            end else if (start) begin
                sh      <= {{WIDTH{1'b0}}, bin} << 1;
                cnt     <= CW'(1);
                running <= 1'b1;
            end else if (running) begin
                sh  <= adj << 1;
                cnt <= cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign bcd = sh[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: latches operands on start, runs add/sub/mul/div, holds the result for display.
// Defining CALC_BCD_EN inserts a binary-to-BCD CONV pass before the result is presented.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int                 WIDTH       = 16,
    parameter logic [2*WIDTH-1:0] ERR_PATTERN = ERR_PATTERN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clr,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic [2*WIDTH-1:0]   cal_result,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 err,
    output logic                 display_en,
    output state_t               state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] res;
    logic               res_err;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] exec_val;
    logic               exec_fin;
    logic               exec_err;
    logic               div_zero;

`ifdef CALC_BCD_EN
    localparam logic [2*WIDTH-1:0] BCD_MAX = (2*WIDTH)'(99_999_999);
    logic [2*WIDTH-1:0] bcd;
    logic               bcd_done;

    calc_bin2bcd #(.WIDTH(2*WIDTH)) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .start (exec_fin),
        .bin   (exec_val),
        .bcd   (bcd),
        .done  (bcd_done)
    );
`endif

    // acc is {high, low}: MUL keeps {partial product, multiplier}, DIV keeps {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = (div_shift >= {1'b0, b_q}) ?
                    {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} :
                    {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        div_zero  = (b_q == '0);
        exec_fin  = 1'b0;
        exec_val  = '0;
        case (op_q)
            OP_ADD: begin
                exec_fin = 1'b1;
                exec_val = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
            end
            OP_SUB: begin
                exec_fin = 1'b1;
                exec_val = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
            end
            OP_MUL: begin
                exec_fin = (cnt == CNT_LAST);
                exec_val = acc;
            end
            default: begin
                exec_fin = div_zero || (cnt == CNT_LAST);
                exec_val = div_zero ? ERR_PATTERN : acc;
            end
        endcase
        exec_fin = exec_fin && (state == EXEC);
        exec_err = (op_q == OP_DIV) && div_zero;
`ifdef CALC_BCD_EN
        exec_err = exec_err || (exec_val > BCD_MAX);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            cnt          <= '0;
            acc          <= '0;
            res          <= '0;
            res_err      <= 1'b0;
            cal_result   <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            display_en   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (clr) begin
                state      <= IDLE;
                cnt        <= '0;
                cal_result <= '0;
                err        <= 1'b0;
                display_en <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE, SHOW: begin
                        // A restart from SHOW keeps the displayed result until the new DONE.
                        if (start) begin
                            op_q  <= op;
                            a_q   <= operand_a;
                            b_q   <= operand_b;
                            cnt   <= '0;
                            acc   <= {{WIDTH{1'b0}}, (op == OP_DIV) ? operand_a : operand_b};
                            busy  <= 1'b1;
                            err   <= 1'b0;
                            state <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (exec_fin) begin
                            res     <= exec_val;
                            res_err <= exec_err;
`ifdef CALC_BCD_EN
                            state   <= CONV;
`else
                            state   <= DONE;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                            acc <= (op_q == OP_MUL) ? mul_next : div_next;
                        end
                    end
`ifdef CALC_BCD_EN
                    CONV: begin
                        if (bcd_done) begin
                            res   <= res_err ? ERR_PATTERN : bcd;
                            state <= DONE;
                        end
                    end
`endif
                    DONE: begin
                        cal_result   <= res;
                        err          <= res_err;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        display_en   <= 1'b1;
                        state        <= SHOW;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: hand-computed results, latencies, clr/reset aborts (CALC_BCD_EN aware).
module tb_calc_ctrl;
    import calc_pkg::*;

    localparam int WIDTH = 16;
`ifdef CALC_BCD_EN
    localparam int          EXTRA = 32;
    localparam logic [31:0] R_5P6 = 32'h0000_0011;
`else
    localparam int          EXTRA = 0;
    localparam logic [31:0] R_5P6 = 32'h0000_000B;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             clr = 1'b0;
    logic [1:0]       op = 2'd0;
    logic [WIDTH-1:0] operand_a = '0;
    logic [WIDTH-1:0] operand_b = '0;
    logic [31:0]      cal_result;
    logic             result_valid;
    logic             busy;
    logic             err;
    logic             display_en;
    state_t           state;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;
    logic        last_disp = 1'b0;

    calc_ctrl #(.WIDTH(WIDTH), .ERR_PATTERN(32'hEEEE_EEEE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .clr          (clr),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .cal_result   (cal_result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err),
        .display_en   (display_en),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(state), 32'(IDLE));
        check({tag, "_cal_result"}, cal_result, 32'h0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_display_en"}, 32'(display_en), 32'h0);
    endtask

    // Issues one operation and follows it to result_valid; noise fires ignored starts and wiggles inputs.
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [31:0] exp_res, input logic exp_err,
                         input logic noise);
        int   lat;
        int   extra;
        logic busy_ok;
        logic hold_ok;
        exp_q.push_back(exp_res);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        check("err_clear_on_start", 32'(err), 32'h0);
        while (!result_valid && lat < 400) begin
            busy_ok = busy_ok & busy;
            hold_ok = hold_ok & (cal_result == last_res) & (display_en == last_disp);
            if (noise) begin
                operand_a = 16'($urandom);
                operand_b = 16'($urandom);
                op        = 2'($urandom);
            end
            start = noise && (lat == 3 || lat == 7);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("result_valid_seen", 32'(result_valid), 32'h1);
        check("latency", lat, exp_lat);
        check("busy_held", 32'(busy_ok), 32'h1);
        check("hold_prev_result", 32'(hold_ok), 32'h1);
        check("cal_result", cal_result, exp_q.pop_front());
        check("err", 32'(err), 32'(exp_err));
        check("display_en", 32'(display_en), 32'h1);
        check("busy_cleared", 32'(busy), 32'h0);
        @(negedge clk);
        check("result_valid_pulse", 32'(result_valid), 32'h0);
        check("state_show", 32'(state), 32'(SHOW));
        if (noise) begin
            extra = 0;
            repeat (60) begin
                @(negedge clk);
                if (result_valid) extra++;
            end
            check("no_extra_result_valid", extra, 0);
        end
        last_res = exp_res;
        last_disp = 1'b1;
    endtask

    initial begin
        int rv_cnt;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

`ifdef CALC_BCD_EN
        do_op(OP_ADD, 16'd9999, 16'd1, 34, 32'h0001_0000, 1'b0, 1'b0);
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 50, 32'hEEEE_EEEE, 1'b1, 1'b1);
        do_op(OP_SUB, 16'd3, 16'd5, 34, 32'hEEEE_EEEE, 1'b1, 1'b0);
        do_op(OP_ADD, 16'd12345, 16'd54321, 34, 32'h0006_6666, 1'b0, 1'b0);
        do_op(OP_DIV, 16'd100, 16'd7, 50, 32'h0013_1086, 1'b0, 1'b0);
        do_op(OP_DIV, 16'd5, 16'd0, 34, 32'hEEEE_EEEE, 1'b1, 1'b0);
`else
        do_op(OP_ADD, 16'h1234, 16'h0FFF, 2, 32'h0000_2233, 1'b0, 1'b0);
        do_op(OP_SUB, 16'd3, 16'd5, 2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 18, 32'hFFFE_0001, 1'b0, 1'b1);
        do_op(OP_DIV, 16'd100, 16'd7, 18, 32'h0002_000E, 1'b0, 1'b0);
        do_op(OP_DIV, 16'd5, 16'd0, 2, 32'hEEEE_EEEE, 1'b1, 1'b0);
        do_op(OP_ADD, 16'd1, 16'd2, 2, 32'h0000_0003, 1'b0, 1'b0);
        do_op(OP_ADD, 16'hFFFF, 16'hFFFF, 2, 32'h0001_FFFE, 1'b0, 1'b0);
        do_op(OP_MUL, 16'h1234, 16'h0010, 18, 32'h0001_2340, 1'b0, 1'b0);
        do_op(OP_DIV, 16'hFFFF, 16'h0001, 18, 32'h0000_FFFF, 1'b0, 1'b0);
`endif

        // clr in the middle of a divide
        @(negedge clk);
        op = OP_DIV; operand_a = 16'd1000; operand_b = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_idle("clr_mid_div");
        rv_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (result_valid) rv_cnt++;
        end
        check("clr_mid_div_no_rv", rv_cnt, 0);
        last_res = '0; last_disp = 1'b0;

        // clr and start together while a result is shown
        do_op(OP_ADD, 16'd5, 16'd6, 2 + EXTRA, R_5P6, 1'b0, 1'b0);
        @(negedge clk);
        op = OP_ADD; operand_a = 16'd7; operand_b = 16'd8; start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        check_idle("clr_with_start");
        rv_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (result_valid) rv_cnt++;
        end
        check("clr_with_start_no_rv", rv_cnt, 0);
        last_res = '0; last_disp = 1'b0;

        // asynchronous reset in the middle of a multiply
        do_op(OP_ADD, 16'd5, 16'd6, 2 + EXTRA, R_5P6, 1'b0, 1'b0);
        @(negedge clk);
        op = OP_MUL; operand_a = 16'h00FF; operand_b = 16'h0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_mul");
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0; last_disp = 1'b0;
        do_op(OP_ADD, 16'd5, 16'd6, 2 + EXTRA, R_5P6, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
